frv_pipeline_execute: RTL and testbench

Execute stage of the backend, directly downstream of dispatch. It consumes the gathered operands and micro-op on the s3_* interface. ALU results take a single cycle; MUL/MULH* use a 32-cycle iterative shift-add multiplier. Results register into the s4 pipeline register, which feeds writeback and drives the hazard-check fields back to dispatch.

---
 rtl/frv_pipeline_execute_pkg.sv | 23 ++
 rtl/frv_mul_iter.sv | 67 ++++++
 rtl/frv_pipeline_execute.sv | 104 ++++++++++
 tb/tb_frv_pipeline_execute.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/frv_pipeline_execute_pkg.sv
// frv_pipeline_execute_pkg: shared FU indices, uop codes and multiplier states
package frv_pipeline_execute_pkg;
    localparam int FU_ALU = 0;
    localparam int FU_MUL = 1;
    localparam int FU_LSU = 2;
    localparam int FU_CSR = 4;
    localparam int LSU_STORE_BIT = 4;
    localparam logic [4:0] ALU_ADD  = 5'd0;
    localparam logic [4:0] ALU_SUB  = 5'd1;
    localparam logic [4:0] ALU_AND  = 5'd2;
    localparam logic [4:0] ALU_OR   = 5'd3;
    localparam logic [4:0] ALU_XOR  = 5'd4;
    localparam logic [4:0] ALU_SLT  = 5'd5;
    localparam logic [4:0] ALU_SLTU = 5'd6;
    localparam logic [4:0] ALU_SLL  = 5'd7;
    localparam logic [4:0] ALU_SRL  = 5'd8;
    localparam logic [4:0] ALU_SRA  = 5'd9;
    localparam logic [4:0] MUL_MUL    = 5'd0;
    localparam logic [4:0] MUL_MULH   = 5'd1;
    localparam logic [4:0] MUL_MULHSU = 5'd2;
    localparam logic [4:0] MUL_MULHU  = 5'd3;
    typedef enum logic [1:0] {MUL_IDLE, MUL_RUN, MUL_DONE} mul_state_e;
endpackage

// File: rtl/frv_mul_iter.sv
// frv_mul_iter: iterative shift-add multiplier, one multiplier bit per cycle
module frv_mul_iter
    import frv_pipeline_execute_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int MUL_ITERS = 32
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            start,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    input  logic            ack,
    output logic            done,
    output logic [XLEN-1:0] result
);
    localparam int CW = $clog2(MUL_ITERS);
    localparam logic [CW-1:0] LAST = CW'(MUL_ITERS - 1);
    mul_state_e state, state_nxt;
    logic [2*XLEN-1:0] acc, md, prod;
    logic [XLEN-1:0] mr, abs_a, abs_b;
    logic [CW-1:0] cnt;
    logic neg, sa, sb, hi;
    assign sa = op == MUL_MULH || op == MUL_MULHSU;
    assign sb = op == MUL_MULH;
    assign hi = sa || op == MUL_MULHU;
    assign abs_a = (sa & a[XLEN-1]) ? -a : a;
    assign abs_b = (sb & b[XLEN-1]) ? -b : b;
    always_comb begin
        state_nxt = state;
        case (state)
            MUL_IDLE: state_nxt = start ? MUL_RUN : MUL_IDLE;
            MUL_RUN:  state_nxt = cnt == LAST ? MUL_DONE : MUL_RUN;
            MUL_DONE: state_nxt = ack ? MUL_IDLE : MUL_DONE;
            default:  state_nxt = MUL_IDLE;
        endcase
        if (flush) state_nxt = MUL_IDLE;
    end
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state <= MUL_IDLE;
            cnt <= '0;
            acc <= '0;
            md <= '0;
            mr <= '0;
            neg <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == MUL_IDLE && state_nxt == MUL_RUN) begin
                md <= {{XLEN{1'b0}}, abs_a};
                mr <= abs_b;
                neg <= (sa & a[XLEN-1]) ^ (sb & b[XLEN-1]);
                acc <= '0;
                cnt <= '0;
            end else if (state == MUL_RUN) begin
                if (mr[cnt]) acc <= acc + md;
                md <= md << 1;
                cnt <= cnt + 1'b1;
            end
        end
    end
    assign done = state == MUL_DONE;
    assign prod = neg ? -acc : acc;
    assign result = hi ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
endmodule

// File: rtl/frv_pipeline_execute.sv
// frv_pipeline_execute: execute stage with inline ALU, iterative multiplier and s4 register
module frv_pipeline_execute
    import frv_pipeline_execute_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int MUL_ITERS = 32
) (
    input  logic            g_clk,
    input  logic            g_reset,
    input  logic            flush,
    input  logic            s3_p_valid,
    output logic            s3_p_busy,
    input  logic [4:0]      s3_rd,
    input  logic [XLEN-1:0] s3_opr_a,
    input  logic [XLEN-1:0] s3_opr_b,
    input  logic [XLEN-1:0] s3_opr_c,
    input  logic [31:0]     s3_pc,
    input  logic [4:0]      s3_uop,
    input  logic [4:0]      s3_fu,
    input  logic            s3_trap,
    input  logic [1:0]      s3_size,
    input  logic [31:0]     s3_instr,
    input  logic            s4_p_busy,
    output logic            s4_p_valid,
    output logic [4:0]      s4_rd,
    output logic [XLEN-1:0] s4_wdata,
    output logic [XLEN-1:0] s4_opr_c,
    output logic [31:0]     s4_pc,
    output logic [31:0]     s4_instr,
    output logic [4:0]      s4_uop,
    output logic [4:0]      s4_fu,
    output logic            s4_trap,
    output logic [1:0]      s4_size,
    output logic            s4_load,
    output logic            s4_csr
);
    localparam int SW = $clog2(XLEN);
    logic fire, mul_done;
    logic [XLEN-1:0] alu, mul_result, wdata;
    logic [SW-1:0] sh;
    assign sh = s3_opr_b[SW-1:0];
    assign s3_p_busy = s4_p_busy | (s3_p_valid & s3_fu[FU_MUL] & ~mul_done);
    assign fire = s3_p_valid & ~s3_p_busy & ~flush;
    frv_mul_iter #(.XLEN(XLEN), .MUL_ITERS(MUL_ITERS)) u_mul (
        .g_clk(g_clk),
        .g_reset(g_reset),
        .start(s3_p_valid & s3_fu[FU_MUL]),
        .op(s3_uop),
        .a(s3_opr_a),
        .b(s3_opr_b),
        .flush(flush),
        .ack(fire),
        .done(mul_done),
        .result(mul_result)
    );
    always_comb begin
        alu = s3_opr_a + s3_opr_b;
        case (s3_uop)
            ALU_SUB:  alu = s3_opr_a - s3_opr_b;
            ALU_AND:  alu = s3_opr_a & s3_opr_b;
            ALU_OR:   alu = s3_opr_a | s3_opr_b;
            ALU_XOR:  alu = s3_opr_a ^ s3_opr_b;
            ALU_SLT:  alu = {{(XLEN-1){1'b0}}, $signed(s3_opr_a) < $signed(s3_opr_b)};
            ALU_SLTU: alu = {{(XLEN-1){1'b0}}, s3_opr_a < s3_opr_b};
            ALU_SLL:  alu = s3_opr_a << sh;
            ALU_SRL:  alu = s3_opr_a >> sh;
            ALU_SRA:  alu = $signed(s3_opr_a) >>> sh;
            default:  alu = s3_opr_a + s3_opr_b;
        endcase
    end
    // LSU/CFU/CSR all produce an address-style sum
    assign wdata = s3_fu[FU_ALU] ? alu : s3_fu[FU_MUL] ? mul_result : s3_opr_a + s3_opr_b;
    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            s4_p_valid <= 1'b0;
            s4_rd <= '0;
            s4_wdata <= '0;
            s4_opr_c <= '0;
            s4_pc <= '0;
            s4_instr <= '0;
            s4_uop <= '0;
            s4_fu <= '0;
            s4_trap <= 1'b0;
            s4_size <= '0;
        end else if (flush) begin
            s4_p_valid <= 1'b0;
        end else if (fire) begin
            s4_p_valid <= 1'b1;
            s4_rd <= s3_rd;
            s4_wdata <= wdata;
            s4_opr_c <= s3_opr_c;
            s4_pc <= s3_pc;
            s4_instr <= s3_instr;
            s4_uop <= s3_uop;
            s4_fu <= s3_fu;
            s4_trap <= s3_trap;
            s4_size <= s3_size;
        end else if (!s4_p_busy) begin
            s4_p_valid <= 1'b0;
        end
    end
    assign s4_load = s4_p_valid & s4_fu[FU_LSU] & ~s4_uop[LSU_STORE_BIT];
    assign s4_csr = s4_p_valid & s4_fu[FU_CSR];
endmodule

// File: tb/tb_frv_pipeline_execute.sv
// tb_frv_pipeline_execute: directed table, hand sequences and randomized ops against a reference model
module tb_frv_pipeline_execute;
    import frv_pipeline_execute_pkg::*;
    logic g_clk = 1'b0, g_reset = 1'b1, flush = 1'b0;
    logic s3_p_valid = 1'b0, s3_p_busy, s3_trap = 1'b0, s4_p_busy = 1'b0;
    logic [4:0] s3_rd = '0, s3_uop = '0, s3_fu = '0;
    logic [31:0] s3_opr_a = '0, s3_opr_b = '0, s3_opr_c = '0, s3_pc = '0, s3_instr = '0;
    logic [1:0] s3_size = '0;
    logic s4_p_valid, s4_trap, s4_load, s4_csr;
    logic [4:0] s4_rd, s4_uop, s4_fu;
    logic [31:0] s4_wdata, s4_opr_c, s4_pc, s4_instr;
    logic [1:0] s4_size;
    int checks = 0, errors = 0;
    always #5 g_clk = ~g_clk;
    frv_pipeline_execute dut (
        .g_clk(g_clk), .g_reset(g_reset), .flush(flush),
        .s3_p_valid(s3_p_valid), .s3_p_busy(s3_p_busy), .s3_rd(s3_rd),
        .s3_opr_a(s3_opr_a), .s3_opr_b(s3_opr_b), .s3_opr_c(s3_opr_c),
        .s3_pc(s3_pc), .s3_uop(s3_uop), .s3_fu(s3_fu), .s3_trap(s3_trap),
        .s3_size(s3_size), .s3_instr(s3_instr), .s4_p_busy(s4_p_busy),
        .s4_p_valid(s4_p_valid), .s4_rd(s4_rd), .s4_wdata(s4_wdata),
        .s4_opr_c(s4_opr_c), .s4_pc(s4_pc), .s4_instr(s4_instr),
        .s4_uop(s4_uop), .s4_fu(s4_fu), .s4_trap(s4_trap), .s4_size(s4_size),
        .s4_load(s4_load), .s4_csr(s4_csr)
    );
    typedef struct {
        string nm;
        logic [4:0] fu;
        logic [4:0] uop;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [4:0] rd;
    } vec_t;
    vec_t vecs[$];
    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", nm, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge g_clk);
        #1;
    endtask
    function automatic logic [31:0] ref_result(input logic [4:0] fu, input logic [4:0] uop,
                                               input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sh;
        sh = int'(b % 32);
        if (fu == 5'b00001) begin
            case (uop)
                0: return a + b;
                1: return a - b;
                2: return a & b;
                3: return a | b;
                4: return a ^ b;
                5: return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
                6: return (a < b) ? 32'd1 : 32'd0;
                7: return a << sh;
                8: return a >> sh;
                9: return 32'(int'(a) / (64'sd1 <<< sh) - ((int'(a) < 0 && (int'(a) % (64'sd1 <<< sh)) != 0) ? 1 : 0));
                default: return a + b;
            endcase
        end
        if (fu == 5'b00010) begin
            ea = (uop == 1 || uop == 2) ? {{32{a[31]}}, a} : {32'b0, a};
            eb = (uop == 1) ? {{32{b[31]}}, b} : {32'b0, b};
            p = ea * eb;
            return (uop == 0) ? p[31:0] : p[63:32];
        end
        return a + b;
    endfunction
    task automatic run_op(input string nm, input logic [4:0] fu, input logic [4:0] uop,
                          input logic [31:0] a, input logic [31:0] b, input logic [31:0] c,
                          input logic [4:0] rd, input logic [31:0] exp);
        int busy_cyc = 0;
        logic [31:0] pc, instr;
        pc = $urandom;
        instr = $urandom;
        s3_fu = fu; s3_uop = uop; s3_opr_a = a; s3_opr_b = b; s3_opr_c = c;
        s3_rd = rd; s3_pc = pc; s3_instr = instr; s3_p_valid = 1'b1;
        #1;
        while (s3_p_busy && busy_cyc < 100) begin
            busy_cyc++;
            tick();
        end
        tick();
        s3_p_valid = 1'b0;
        chk({nm, " busy_cycles"}, busy_cyc, (fu == 5'b00010) ? 32'd33 : 32'd0);
        chk({nm, " valid"}, {31'b0, s4_p_valid}, 32'd1);
        chk({nm, " wdata"}, s4_wdata, exp);
        chk({nm, " rd"}, {27'b0, s4_rd}, {27'b0, rd});
        chk({nm, " opr_c"}, s4_opr_c, c);
        chk({nm, " pc"}, s4_pc, pc);
        chk({nm, " instr"}, s4_instr, instr);
        chk({nm, " uop_fu"}, {22'b0, s4_uop, s4_fu}, {22'b0, uop, fu});
        chk({nm, " load"}, {31'b0, s4_load}, {31'b0, fu[2] & ~uop[4]});
        chk({nm, " csr"}, {31'b0, s4_csr}, {31'b0, fu[4]});
    endtask
    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return 32'h80000000;
            1: return 32'hffffffff;
            default: return $urandom;
        endcase
    endfunction
    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end
    initial begin
        int nv;
        vecs.push_back('{"add_ovf", 5'd1, ALU_ADD, 32'h7fffffff, 32'h1, 32'h80000000, 5'd5});
        vecs.push_back('{"sra", 5'd1, ALU_SRA, 32'h80000000, 32'h24, 32'hf8000000, 5'd1});
        vecs.push_back('{"slt", 5'd1, ALU_SLT, 32'hffffffff, 32'h0, 32'h1, 5'd2});
        vecs.push_back('{"sltu", 5'd1, ALU_SLTU, 32'hffffffff, 32'h0, 32'h0, 5'd3});
        vecs.push_back('{"sub", 5'd1, ALU_SUB, 32'h0, 32'h1, 32'hffffffff, 5'd4});
        vecs.push_back('{"and", 5'd1, ALU_AND, 32'hf0f0, 32'hff00, 32'hf000, 5'd6});
        vecs.push_back('{"or", 5'd1, ALU_OR, 32'hf0f0, 32'hff00, 32'hfff0, 5'd7});
        vecs.push_back('{"xor", 5'd1, ALU_XOR, 32'hf0f0, 32'hff00, 32'h0ff0, 5'd8});
        vecs.push_back('{"sll", 5'd1, ALU_SLL, 32'h1, 32'h3f, 32'h80000000, 5'd9});
        vecs.push_back('{"srl", 5'd1, ALU_SRL, 32'h80000000, 32'h24, 32'h08000000, 5'd10});
        vecs.push_back('{"mul", 5'd2, MUL_MUL, 32'd7, 32'd6, 32'd42, 5'd11});
        vecs.push_back('{"mulhu", 5'd2, MUL_MULHU, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 5'd12});
        vecs.push_back('{"mulh", 5'd2, MUL_MULH, 32'hffffffff, 32'hffffffff, 32'h0, 5'd13});
        vecs.push_back('{"mulhsu", 5'd2, MUL_MULHSU, 32'hffffffff, 32'h2, 32'hffffffff, 5'd14});
        vecs.push_back('{"mulh_min", 5'd2, MUL_MULH, 32'h80000000, 32'h80000000, 32'h40000000, 5'd15});
        vecs.push_back('{"lsu_load", 5'd4, 5'd0, 32'h1000, 32'h20, 32'h1020, 5'd16});
        vecs.push_back('{"lsu_store", 5'd4, 5'h10, 32'h2000, 32'h4, 32'h2004, 5'd17});
        vecs.push_back('{"csr", 5'd16, 5'd1, 32'h300, 32'h5, 32'h305, 5'd18});
        tick();
        tick();
        chk("reset valid", {31'b0, s4_p_valid}, 32'd0);
        chk("reset wdata", s4_wdata, 32'd0);
        chk("reset busy", {31'b0, s3_p_busy}, 32'd0);
        g_reset = 1'b0;
        tick();
        nv = vecs.size();
        for (int i = 0; i < nv; i++)
            run_op(vecs[i].nm, vecs[i].fu, vecs[i].uop, vecs[i].a, vecs[i].b, $urandom, vecs[i].rd, vecs[i].exp);
        tick();
        chk("drain valid", {31'b0, s4_p_valid}, 32'd0);
        // backpressure: s4 holds while the next op waits
        run_op("bp_first", 5'd1, ALU_ADD, 32'd1, 32'd2, 32'd0, 5'd3, 32'd3);
        s3_fu = 5'd1; s3_uop = ALU_ADD; s3_opr_a = 32'd10; s3_opr_b = 32'd20; s3_rd = 5'd4;
        s3_p_valid = 1'b1;
        s4_p_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp hold valid", {31'b0, s4_p_valid}, 32'd1);
            chk("bp hold wdata", s4_wdata, 32'd3);
            chk("bp hold rd", {27'b0, s4_rd}, 32'd3);
            chk("bp s3_busy", {31'b0, s3_p_busy}, 32'd1);
        end
        s4_p_busy = 1'b0;
        #1;
        chk("bp release busy", {31'b0, s3_p_busy}, 32'd0);
        tick();
        s3_p_valid = 1'b0;
        chk("bp next valid", {31'b0, s4_p_valid}, 32'd1);
        chk("bp next wdata", s4_wdata, 32'd30);
        chk("bp next rd", {27'b0, s4_rd}, 32'd4);
        tick();
        chk("bp drain", {31'b0, s4_p_valid}, 32'd0);
        // flush mid-multiply
        s3_fu = 5'd2; s3_uop = MUL_MUL; s3_opr_a = 32'd7; s3_opr_b = 32'd6; s3_rd = 5'd9;
        s3_p_valid = 1'b1;
        repeat (10) tick();
        chk("flush pre busy", {31'b0, s3_p_busy}, 32'd1);
        flush = 1'b1;
        s3_p_valid = 1'b0;
        tick();
        flush = 1'b0;
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (s4_p_valid) seen++;
                tick();
            end
            chk("flush no output", seen, 32'd0);
        end
        // reset mid-multiply
        s3_fu = 5'd2; s3_uop = MUL_MUL; s3_opr_a = 32'd9; s3_opr_b = 32'd9; s3_rd = 5'd7;
        s3_p_valid = 1'b1;
        repeat (5) tick();
        chk("rst pre busy", {31'b0, s3_p_busy}, 32'd1);
        g_reset = 1'b1;
        tick();
        g_reset = 1'b0;
        s3_p_valid = 1'b0;
        chk("rst valid", {31'b0, s4_p_valid}, 32'd0);
        chk("rst wdata", s4_wdata, 32'd0);
        chk("rst rd", {27'b0, s4_rd}, 32'd0);
        chk("rst pc", s4_pc, 32'd0);
        chk("rst fu_uop", {22'b0, s4_uop, s4_fu}, 32'd0);
        begin
            int seen = 0;
            for (int i = 0; i < 40; i++) begin
                if (s4_p_valid) seen++;
                tick();
            end
            chk("rst no output", seen, 32'd0);
        end
        run_op("post_rst_mul", 5'd2, MUL_MUL, 32'd3, 32'd5, 32'd0, 5'd1, 32'd15);
        for (int i = 0; i < 40; i++) begin
            int k;
            logic [4:0] fu, uop;
            logic [31:0] a, b;
            k = $urandom_range(0, 3);
            fu = (k == 3) ? 5'b10000 : 5'(1 << k);
            uop = (k == 0) ? 5'($urandom_range(0, 9)) : (k == 1) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
            a = pick();
            b = pick();
            run_op($sformatf("rnd%0d", i), fu, uop, a, b, $urandom, 5'($urandom_range(0, 31)), ref_result(fu, uop, a, b));
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
